fetch_decode_stage: RTL and testbench

Byte-serial instruction fetch-and-decode stage for the 16-bit CPU. It assembles 16-bit instructions, plus an optional inline data byte, from an 8-bit byte stream using a valid/ready handshake. It decodes each instruction into a registered micro-op bundle and hands it to the execute stage over a second valid/ready handshake. It sits between the external byte interface and the ALU/register file. Its datapath width is parametrised, and it adds an illegal-instruction flag and a pipeline flush.

---
 rtl/fetch_decode_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_fetch_decode_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Byte-serial fetch/decode stage: assembles 16-bit instructions plus an
// optional inline data byte and presents a registered micro-op bundle.
module fetch_decode_stage #(
    parameter int WIDTH    = 16,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_inst,
    output logic [11:0]      out_op,
    output logic [WIDTH-1:0] out_rhs,
    output logic             out_src_imm,
    output logic             out_src_ram,
    output logic [3:0]       out_cond,
    output logic             out_illegal
);

    typedef enum logic [1:0] {
        S_FIRST,
        S_SECOND,
        S_DATA
    } state_e;

    localparam int OP_NOP    = 0;
    localparam int OP_NOT    = 1;
    localparam int OP_OUTLO  = 2;
    localparam int OP_LOAD   = 3;
    localparam int OP_STORE  = 4;
    localparam int OP_ADD    = 5;
    localparam int OP_SUB    = 6;
    localparam int OP_AND    = 7;
    localparam int OP_OR     = 8;
    localparam int OP_XOR    = 9;
    localparam int OP_BRANCH = 10;
    localparam int OP_IF     = 11;

    state_e state_q, state_d;
    logic [7:0]  first_q, first_d;
    logic [15:0] inst_q, inst_d;

    logic             valid_q, valid_d;
    logic [15:0]      oinst_q, oinst_d;
    logic [11:0]      op_q, op_d;
    logic [WIDTH-1:0] rhs_q, rhs_d;
    logic             imm_q, imm_d;
    logic             ram_q, ram_d;
    logic [3:0]       cond_q, cond_d;
    logic             ill_q, ill_d;

    logic [15:0]      asm_inst;
    logic [15:0]      dec_inst;
    logic [4:0]       opc;
    logic [2:0]       src;
    logic [7:0]       imm8;
    logic             alu;
    logic [11:0]      dec_op;
    logic [WIDTH-1:0] dec_rhs;
    logic             dec_imm;
    logic             dec_ram;
    logic [3:0]       dec_cond;
    logic             dec_ill;
    logic             dec_need;
    logic             xfer;
    logic             load;

    assign asm_inst = HI_FIRST ? {first_q, in_byte} : {in_byte, first_q};

    // In DATA the instruction word is already latched; in_byte is the data.
    always_comb begin
        dec_inst = (state_q == S_DATA) ? inst_q : asm_inst;
        opc      = dec_inst[15:11];
        src      = dec_inst[10:8];
        imm8     = dec_inst[7:0];
        alu      = 1'b0;
        dec_op   = '0;
        dec_rhs  = '0;
        dec_imm  = 1'b0;
        dec_ram  = 1'b0;
        dec_cond = '0;
        dec_ill  = 1'b0;
        dec_need = 1'b0;

        if (!opc[4]) begin
            case (dec_inst[15:8])
                8'h00:   dec_op[OP_NOP]   = 1'b1;
                8'h07:   dec_op[OP_NOT]   = 1'b1;
                8'h08:   dec_op[OP_OUTLO] = 1'b1;
                default: dec_ill          = 1'b1;
            endcase
        end else begin
            case (opc)
                5'b10000: begin dec_op[OP_LOAD]  = 1'b1; alu = 1'b1; end
                5'b10001: begin dec_op[OP_ADD]   = 1'b1; alu = 1'b1; end
                5'b10010: begin dec_op[OP_STORE] = 1'b1; alu = 1'b1; end
                5'b10011: begin dec_op[OP_SUB]   = 1'b1; alu = 1'b1; end
                5'b10100: begin dec_op[OP_AND]   = 1'b1; alu = 1'b1; end
                5'b10101: begin dec_op[OP_OR]    = 1'b1; alu = 1'b1; end
                5'b10110: begin dec_op[OP_XOR]   = 1'b1; alu = 1'b1; end
                5'b11000: begin
                    dec_op[OP_BRANCH] = 1'b1;
                    dec_rhs = {{(WIDTH-11){dec_inst[10]}}, dec_inst[10:0]};
                end
                5'b11110: begin
                    dec_op[OP_IF] = 1'b1;
                    case (dec_inst[10:0])
                        11'h000: dec_cond = 4'b0001;
                        11'h001: dec_cond = 4'b0010;
                        11'h010: dec_cond = 4'b0100;
                        11'h011: dec_cond = 4'b1000;
                        default: dec_ill  = 1'b1;
                    endcase
                end
                default: dec_ill = 1'b1;
            endcase
        end

        if (alu) begin
            case (src)
                3'b000: begin
                    dec_rhs[7:0] = imm8;
                    dec_imm      = 1'b1;
                end
                3'b001: begin
                    dec_rhs[15:8] = imm8;
                    dec_imm       = 1'b1;
                end
                3'b010: begin
                    dec_rhs[7:0] = in_byte;
                    dec_imm      = 1'b1;
                    dec_need     = 1'b1;
                end
                3'b011: begin
                    dec_rhs[15:8] = in_byte;
                    dec_imm       = 1'b1;
                    dec_need      = 1'b1;
                end
                3'b100: begin
                    dec_rhs[7:0] = imm8;
                    dec_ram      = 1'b1;
                end
                default: dec_ill = 1'b1;
            endcase
        end

        // Illegal encodings travel as an empty bundle and never pull data.
        if (dec_ill) begin
            dec_op   = '0;
            dec_rhs  = '0;
            dec_imm  = 1'b0;
            dec_ram  = 1'b0;
            dec_cond = '0;
            dec_need = 1'b0;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst && !flush) begin
            if (state_q == S_FIRST) in_ready = 1'b1;
            else                    in_ready = !valid_q || out_ready;
        end
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        inst_d  = inst_q;
        load    = 1'b0;
        case (state_q)
            S_FIRST: begin
                if (xfer) begin
                    first_d = in_byte;
                    state_d = S_SECOND;
                end
            end
            S_SECOND: begin
                if (xfer) begin
                    inst_d = asm_inst;
                    if (dec_need) begin
                        state_d = S_DATA;
                    end else begin
                        load    = 1'b1;
                        state_d = S_FIRST;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    load    = 1'b1;
                    state_d = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
        if (flush) state_d = S_FIRST;
    end

    always_comb begin
        valid_d = valid_q && !out_ready;
        oinst_d = oinst_q;
        op_d    = op_q;
        rhs_d   = rhs_q;
        imm_d   = imm_q;
        ram_d   = ram_q;
        cond_d  = cond_q;
        ill_d   = ill_q;
        if (load) begin
            valid_d = 1'b1;
            oinst_d = dec_inst;
            op_d    = dec_op;
            rhs_d   = dec_rhs;
            imm_d   = dec_imm;
            ram_d   = dec_ram;
            cond_d  = dec_cond;
            ill_d   = dec_ill;
        end
        if (flush) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FIRST;
            first_q <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            oinst_q <= '0;
            op_q    <= '0;
            rhs_q   <= '0;
            imm_q   <= 1'b0;
            ram_q   <= 1'b0;
            cond_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            oinst_q <= oinst_d;
            op_q    <= op_d;
            rhs_q   <= rhs_d;
            imm_q   <= imm_d;
            ram_q   <= ram_d;
            cond_q  <= cond_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_inst    = oinst_q;
    assign out_op      = op_q;
    assign out_rhs     = rhs_q;
    assign out_src_imm = imm_q;
    assign out_src_ram = ram_q;
    assign out_cond    = cond_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage (WIDTH=32, high byte first): vector table
// with a scoreboard queue, plus stall, flush and reset sequences.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [11:0] out_op;
    logic [31:0] out_rhs;
    logic        out_src_imm;
    logic        out_src_ram;
    logic [3:0]  out_cond;
    logic        out_illegal;

    fetch_decode_stage #(.WIDTH(32), .HI_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_op(out_op), .out_rhs(out_rhs),
        .out_src_imm(out_src_imm), .out_src_ram(out_src_ram),
        .out_cond(out_cond), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        int          n;
        logic [11:0] op;
        logic [31:0] rhs;
        logic        imm, ram;
        logic [3:0]  cond;
        logic        ill;
    } vec_t;

    vec_t tbl[24];
    vec_t sb[$];
    vec_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stalls = 0;
    int   st0;

    function automatic vec_t mk(
        input logic [7:0] b0, b1, b2, input int n,
        input logic [11:0] op, input logic [31:0] rhs,
        input logic imm, ram, input logic [3:0] cond, input logic ill);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n;
        v.op = op; v.rhs = rhs; v.imm = imm; v.ram = ram;
        v.cond = cond; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        in_byte = b;
        in_valid = 1'b1;
        while (!ok && n < 40) begin
            #1;
            ok = in_ready;
            @(negedge clk);
            if (!ok) begin
                n++;
                stalls++;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_t v);
        send_byte(v.b0);
        send_byte(v.b1);
        if (v.n == 3) send_byte(v.b2);
    endtask

    // Handshake happens at the next posedge when both are high here.
    always begin
        @(negedge clk);
        #3;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_bundle: got inst %h expected none",
                         out_inst);
            end else begin
                e = sb.pop_front();
                chk("inst", {16'h0, out_inst}, {16'h0, e.b0, e.b1});
                chk("op", {20'h0, out_op}, {20'h0, e.op});
                chk("rhs", out_rhs, e.rhs);
                chk("flags",
                    {25'h0, out_src_imm, out_src_ram, out_cond, out_illegal},
                    {25'h0, e.imm, e.ram, e.cond, e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(8'h88, 8'h05, 8'h00, 2, 12'h020, 32'h5, 1, 0, 4'h0, 0);
        tbl[1]  = mk(8'h8A, 8'h00, 8'hAB, 3, 12'h020, 32'hAB, 1, 0, 4'h0, 0);
        tbl[2]  = mk(8'h8B, 8'h00, 8'hCD, 3, 12'h020, 32'hCD00, 1, 0, 4'h0, 0);
        tbl[3]  = mk(8'hC7, 8'hFE, 8'h00, 2, 12'h400, 32'hFFFFFFFE, 0, 0, 4'h0, 0);
        tbl[4]  = mk(8'hF0, 8'h11, 8'h00, 2, 12'h800, 32'h0, 0, 0, 4'h8, 0);
        tbl[5]  = mk(8'hE0, 8'h00, 8'h00, 2, 12'h000, 32'h0, 0, 0, 4'h0, 1);
        tbl[6]  = mk(8'h01, 8'h00, 8'h00, 2, 12'h000, 32'h0, 0, 0, 4'h0, 1);
        tbl[7]  = mk(8'h8D, 8'h00, 8'h00, 2, 12'h000, 32'h0, 0, 0, 4'h0, 1);
        tbl[8]  = mk(8'h00, 8'h00, 8'h00, 2, 12'h001, 32'h0, 0, 0, 4'h0, 0);
        tbl[9]  = mk(8'h07, 8'h33, 8'h00, 2, 12'h002, 32'h0, 0, 0, 4'h0, 0);
        tbl[10] = mk(8'h08, 8'h00, 8'h00, 2, 12'h004, 32'h0, 0, 0, 4'h0, 0);
        tbl[11] = mk(8'h84, 8'h12, 8'h00, 2, 12'h008, 32'h12, 0, 1, 4'h0, 0);
        tbl[12] = mk(8'h91, 8'h34, 8'h00, 2, 12'h010, 32'h3400, 1, 0, 4'h0, 0);
        tbl[13] = mk(8'h98, 8'hFF, 8'h00, 2, 12'h040, 32'hFF, 1, 0, 4'h0, 0);
        tbl[14] = mk(8'hA2, 8'h00, 8'h77, 3, 12'h080, 32'h77, 1, 0, 4'h0, 0);
        tbl[15] = mk(8'hAB, 8'h00, 8'h55, 3, 12'h100, 32'h5500, 1, 0, 4'h0, 0);
        tbl[16] = mk(8'hB0, 8'h0F, 8'h00, 2, 12'h200, 32'h0F, 1, 0, 4'h0, 0);
        tbl[17] = mk(8'hC0, 8'h01, 8'h00, 2, 12'h400, 32'h1, 0, 0, 4'h0, 0);
        tbl[18] = mk(8'hF0, 8'h10, 8'h00, 2, 12'h800, 32'h0, 0, 0, 4'h4, 0);
        tbl[19] = mk(8'hF0, 8'h00, 8'h00, 2, 12'h800, 32'h0, 0, 0, 4'h1, 0);
        tbl[20] = mk(8'hF0, 8'h01, 8'h00, 2, 12'h800, 32'h0, 0, 0, 4'h2, 0);
        tbl[21] = mk(8'hF1, 8'h00, 8'h00, 2, 12'h000, 32'h0, 0, 0, 4'h0, 1);
        tbl[22] = mk(8'h86, 8'h00, 8'h00, 2, 12'h000, 32'h0, 0, 0, 4'h0, 1);
        tbl[23] = mk(8'hB8, 8'h00, 8'h00, 2, 12'h000, 32'h0, 0, 0, 4'h0, 1);

        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_byte = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_inst_op", {4'h0, out_inst, out_op}, 32'h0);
        chk("rst_rhs", out_rhs, 32'h0);
        chk("rst_flags",
            {25'h0, out_src_imm, out_src_ram, out_cond, out_illegal}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            sb.push_back(tbl[i]);
            send_vec(tbl[i]);
            chk("latency_valid", {31'h0, out_valid}, 32'h1);
        end
        chk("table_stalls", stalls, 32'h0);
        @(negedge clk);
        chk("valid_clears", {31'h0, out_valid}, 32'h0);

        // Stall: bundle held, next instruction blocked in SECOND.
        out_ready = 1'b0;
        sb.push_back(tbl[0]);
        send_vec(tbl[0]);
        send_byte(8'h8A);
        in_byte = 8'h00;
        in_valid = 1'b1;
        #1;
        chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_stable", {out_inst, 15'h0, out_valid}, 32'h88050001);
            chk("hold_rhs", out_rhs, 32'h5);
        end
        sb.push_back(tbl[1]);
        out_ready = 1'b1;
        st0 = stalls;
        send_byte(8'h00);
        send_byte(8'hAB);
        chk("release_no_bubble", stalls - st0, 32'h0);
        @(negedge clk);

        // Flush after the first byte.
        send_byte(8'h88);
        flush = 1'b1;
        in_byte = 8'h05;
        in_valid = 1'b1;
        #1;
        chk("flush_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        sb.push_back(tbl[13]);
        send_vec(tbl[13]);
        @(negedge clk);

        // Flush with a held bundle.
        out_ready = 1'b0;
        send_vec(tbl[0]);
        chk("pre_flush_valid", {31'h0, out_valid}, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b1;
        sb.push_back(tbl[17]);
        send_vec(tbl[17]);
        @(negedge clk);

        // Reset after the first byte.
        send_byte(8'h88);
        rst = 1'b1;
        in_byte = 8'h05;
        in_valid = 1'b1;
        #1;
        chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        sb.push_back(tbl[4]);
        send_vec(tbl[4]);
        @(negedge clk);

        // Reset with a held bundle.
        out_ready = 1'b0;
        send_vec(tbl[14]);
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hold_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_hold_inst", {16'h0, out_inst}, 32'h0);
        out_ready = 1'b1;
        sb.push_back(tbl[2]);
        send_vec(tbl[2]);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
